// File: rtl/tiny_cpu_pkg.sv
// Definitions shared by the tiny 8-bit processor: bus widths, opcode encodings
// and the fetch-stage state type.
package tiny_cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_LDI  = 8'h10;
  localparam logic [7:0] OPC_ADD  = 8'h20;
  localparam logic [7:0] OPC_SUB  = 8'h30;
  localparam logic [7:0] OPC_JMP  = 8'h40;
  localparam logic [7:0] OPC_BEQ  = 8'h50;
  localparam logic [7:0] OPC_HALT = 8'hFF;

  typedef enum logic [0:0] {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [7:0] instr);
    return instr == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers memory data into the IR,
// presents it to decode over valid/ready, applies redirects and stops on HALT.
module fetch_unit
  import tiny_cpu_pkg::*;
#(
  parameter int                      ADDR_W     = tiny_cpu_pkg::ADDR_W,
  parameter int                      INSTR_W    = tiny_cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]       RESET_PC   = '0,
  parameter logic [INSTR_W-1:0]      HALT_INSTR = '1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               halted
);

  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic [ADDR_W-1:0]  ir_pc_reg, ir_pc_next;
  logic               ir_valid_reg, ir_valid_next;
  logic               halted_reg, halted_next;
  logic               load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= FETCH_RUN;
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      ir_pc_reg    <= '0;
      ir_valid_reg <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      ir_pc_reg    <= ir_pc_next;
      ir_valid_reg <= ir_valid_next;
      halted_reg   <= halted_next;
    end
  end

  // A new instruction may enter the IR whenever it is empty or being consumed.
  assign load = (state_reg == FETCH_RUN) && (!ir_valid_reg || ir_ready);

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    ir_pc_next    = ir_pc_reg;
    ir_valid_next = ir_valid_reg;
    halted_next   = halted_reg;

    case (state_reg)
      FETCH_RUN: begin
        if (redirect_valid) begin
          // Flush the wrong-path IR; the target is fetched next cycle.
          pc_next       = redirect_target;
          ir_valid_next = 1'b0;
        end else if (load) begin
          ir_next       = instr_in;
          ir_pc_next    = pc_reg;
          ir_valid_next = 1'b1;
          if (instr_in == HALT_INSTR) begin
            state_next  = FETCH_HALTED;
            halted_next = 1'b1;
          end else begin
            pc_next = pc_reg + ADDR_W'(1);
          end
        end
      end

      FETCH_HALTED: begin
        // HALT stays visible until decode takes it; redirects are ignored.
        if (ir_valid_reg && ir_ready) begin
          ir_valid_next = 1'b0;
        end
      end

      default: begin
        state_next = FETCH_RUN;
      end
    endcase
  end

  assign pc_out   = pc_reg;
  assign ir_out   = ir_reg;
  assign ir_pc    = ir_pc_reg;
  assign ir_valid = ir_valid_reg;
  assign halted   = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic, compared against a transaction-level reference model.
module tb_fetch_unit;

  logic       clk;
  logic       reset;
  logic [7:0] pc_out;
  logic [7:0] instr_in;
  logic [7:0] ir_out;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       ir_ready;
  logic       redirect_valid;
  logic [7:0] redirect_target;
  logic       halted;

  logic [7:0] mem [256];

  int n_checks;
  int n_fail;

  // Reference model state, kept as plain integers.
  int m_pc, m_ir, m_ir_pc, m_valid, m_halted;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pc_out          (pc_out),
    .instr_in        (instr_in),
    .ir_out          (ir_out),
    .ir_pc           (ir_pc),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted)
  );

  assign instr_in = mem[pc_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the fetch rules.
  task automatic model_edge(input bit rst, input bit rdy, input bit rv, input int tgt);
    if (rst) begin
      m_pc = 0; m_ir = 0; m_ir_pc = 0; m_valid = 0; m_halted = 0;
    end else if (m_halted != 0) begin
      if (m_valid != 0 && rdy) m_valid = 0;
    end else if (rv) begin
      m_pc    = tgt;
      m_valid = 0;
    end else if (m_valid == 0 || rdy) begin
      m_ir    = mem[m_pc];
      m_ir_pc = m_pc;
      m_valid = 1;
      if (m_ir == 8'hFF) m_halted = 1;
      else m_pc = (m_pc + 1) % 256;
    end
  endtask

  // One transaction: drive inputs at negedge, clock, then compare after the edge.
  task automatic step(input bit rst, input bit rdy, input bit rv, input int tgt);
    @(negedge clk);
    reset           = rst;
    ir_ready        = rdy;
    redirect_valid  = rv;
    redirect_target = 8'(tgt);
    model_edge(rst, rdy, rv, tgt);
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b rdy=%0b rv=%0b tgt=%02h | pc=%02h ir=%02h ir_pc=%02h v=%0b h=%0b",
             $time, rst, rdy, rv, tgt[7:0], pc_out, ir_out, ir_pc, ir_valid, halted);
    check_eq("pc_out",   int'(pc_out),   m_pc);
    check_eq("ir_valid", int'(ir_valid), m_valid);
    check_eq("halted",   int'(halted),   m_halted);
    check_eq("ir_out",   int'(ir_out),   m_ir);
    check_eq("ir_pc",    int'(ir_pc),    m_ir_pc);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'h91; mem[1] = 8'h92; mem[2] = 8'h93; mem[3] = 8'hFF;
    m_pc = 0; m_ir = 0; m_ir_pc = 0; m_valid = 0; m_halted = 0;

    // Reset state
    do_reset();
    do_reset();
    check_eq("rst_pc", int'(pc_out), 0);
    check_eq("rst_valid", int'(ir_valid), 0);
    check_eq("rst_halted", int'(halted), 0);
    check_eq("rst_ir", int'(ir_out), 0);

    // Sequential fetch to HALT
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("seq0_ir", int'(ir_out), 8'h91);
    check_eq("seq0_pc", int'(ir_pc), 0);
    check_eq("seq0_valid", int'(ir_valid), 1);
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("seq1_ir", int'(ir_out), 8'h92);
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("seq2_ir", int'(ir_out), 8'h93);
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("seq3_ir", int'(ir_out), 8'hFF);
    check_eq("seq3_irpc", int'(ir_pc), 3);
    check_eq("seq3_halted", int'(halted), 1);
    check_eq("seq3_pc", int'(pc_out), 3);
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("seq4_valid", int'(ir_valid), 0);
    check_eq("seq4_pc", int'(pc_out), 3);
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("seq5_valid", int'(ir_valid), 0);

    // Stall while IR holds 0x92
    do_reset();
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 0);
      check_eq("stall_ir", int'(ir_out), 8'h92);
      check_eq("stall_irpc", int'(ir_pc), 1);
      check_eq("stall_pc", int'(pc_out), 2);
    end
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("stall_release_ir", int'(ir_out), 8'h93);

    // Redirect flushes IR even when decode is not ready
    mem[3] = 8'hA3;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 3);
    check_eq("redir_valid", int'(ir_valid), 0);
    check_eq("redir_pc", int'(pc_out), 3);
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("redir_ir", int'(ir_out), 8'hA3);
    check_eq("redir_irpc", int'(ir_pc), 3);

    // Redirect wins over a HALT on instr_in
    mem[1] = 8'hFF; mem[4] = 8'hA4;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 4);
    check_eq("rvh_halted", int'(halted), 0);
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("rvh_ir", int'(ir_out), 8'hA4);
    check_eq("rvh_irpc", int'(ir_pc), 4);
    check_eq("rvh_halted2", int'(halted), 0);
    mem[1] = 8'h92;

    // PC wrap, then redirect ignored while halted
    mem[8'hFF] = 8'h5A; mem[3] = 8'hFF;
    do_reset();
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("wrap_pc", int'(pc_out), 0);
    check_eq("wrap_irpc", int'(ir_pc), 8'hFF);
    step(1'b0, 1'b1, 1'b1, 3);
    step(1'b0, 1'b0, 1'b0, 0);
    check_eq("hlt_halted", int'(halted), 1);
    step(1'b0, 1'b0, 1'b1, 8'h10);
    check_eq("hlt_ign_pc", int'(pc_out), 3);
    check_eq("hlt_ign_halted", int'(halted), 1);
    check_eq("hlt_ign_valid", int'(ir_valid), 1);
    step(1'b0, 1'b1, 1'b0, 0);
    check_eq("hlt_drain_valid", int'(ir_valid), 0);

    // Reset mid-stall
    do_reset();
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    check_eq("rst_stall_valid", int'(ir_valid), 0);
    check_eq("rst_stall_pc", int'(pc_out), 0);
    check_eq("rst_stall_halted", int'(halted), 0);

    // Randomized traffic over a sparse-HALT program
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0) || (m_halted != 0 && $urandom_range(0, 5) == 0),
           1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 8-bit tiny processor. It owns the program counter, drives the address port of the combinational instruction memory, and registers each returned byte into an instruction register (IR). The IR is presented to decode with a valid/ready handshake. The block also applies control-flow redirects from execute and stops fetching when it loads the HALT instruction.

## Interface
Parameters:
- `ADDR_W`, 8: PC / memory address width.
- `INSTR_W`, 8: instruction width.
- `RESET_PC`, 8'h00: PC value after reset.
- `HALT_INSTR`, 8'hFF: encoding that halts fetch.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `pc_out` out ADDR_W: address to instruction memory, driven directly from the PC register.
- `instr_in` in INSTR_W: instruction memory data, combinational from `pc_out`.
- `ir_out` out INSTR_W: registered instruction to decode.
- `ir_pc` out ADDR_W: address from which `ir_out` was fetched.
- `ir_valid` out 1: `ir_out` holds an unconsumed instruction.
- `ir_ready` in 1: decode accepts `ir_out` this cycle.
- `redirect_valid` in 1: execute requests a PC change.
- `redirect_target` in ADDR_W: new PC for the redirect.
- `halted` out 1: fetch stopped on HALT; sticky until reset.

## Operation
- States: RUN and HALTED. The state is RUN after reset.
- Reset values:
  - PC = `RESET_PC`
  - `ir_out` = 0
  - `ir_pc` = 0
  - `ir_valid` = 0
  - `halted` = 0
- Load condition: `load = (state==RUN) && (!ir_valid || ir_ready)`.
- Priority order in RUN: `redirect_valid` first, then `load`, then hold.
- Redirect (RUN):
  - PC ← `redirect_target`.
  - `ir_valid` ← 0, which flushes the wrong-path IR even if decode is not ready.
  - No instruction is loaded that cycle.
  - A HALT present on `instr_in` that cycle is discarded and does not halt.
- Load, no redirect:
  - IR ← `instr_in`, `ir_pc` ← PC, `ir_valid` ← 1.
  - If `instr_in == HALT_INSTR`: state ← HALTED, `halted` ← 1, PC unchanged (stays pointing at the HALT).
  - Otherwise: PC ← PC+1, modulo 2^ADDR_W (8'hFF wraps to 8'h00).
- Stall (`ir_valid && !ir_ready`, no redirect): PC, IR, `ir_pc` and `ir_valid` all hold.
- HALTED:
  - The HALT instruction remains in IR until decode accepts it; `ir_valid` then falls to 0.
  - No further loads occur.
  - `redirect_valid` is ignored.
  - Only `reset` leaves HALTED.
- Reset asserted in any state or mid-stall: all state returns to reset values on that edge, and any in-flight IR is dropped.
- No range check on PC. Memory contents beyond the program are the memory's concern.

## Timing
- `pc_out` changes only on clock edges.
- `instr_in` is sampled at the same edge that updates PC.
- Latency:
  - From PC value to `ir_valid`: 1 cycle.
  - From reset deassertion to first `ir_valid`: 1 cycle, carrying the instruction at `RESET_PC`.
- Throughput: 1 instruction/cycle while `ir_ready` is held high.
- Redirect cost: 1 bubble. The target instruction appears in IR 2 edges after the redirect cycle.
- `halted` rises on the same edge that loads HALT into IR.
- Handshake rule: `ir_out` and `ir_pc` are stable while `ir_valid && !ir_ready`.

## Structure
- Package `tiny_cpu_pkg` holds the shared definitions used by fetch, decode and instruction memory:
  - `ADDR_W`, `INSTR_W`
  - the opcode constants, including `OPC_HALT = 8'hFF`
  - the fetch state enum {RUN, HALTED}
- No sub-module. The block is one FSM plus the PC and IR registers; the increment and compare logic stay inline.

## Test plan
- Sequential fetch: memory holds 8'h91, 8'h92, 8'h93, 8'hFF at 0..3; `ir_ready`=1.
  - IR shows 91/92/93/FF with `ir_pc` 0/1/2/3 on consecutive cycles.
  - `halted`=1 on the FF load; PC stays at 3.
  - `ir_valid`=0 from the next cycle onward.
- Stall: `ir_ready`=0 for 3 cycles while IR=8'h92.
  - `ir_out`, `ir_pc`=1 and `pc_out`=2 are unchanged throughout.
  - When `ir_ready` rises, 8'h93 loads on the next edge.
- Redirect: `redirect_valid`=1 with target 8'h03 while IR holds 8'h91.
  - Next cycle: `ir_valid`=0 and `pc_out`=3.
  - Following cycle: IR = mem[3] with `ir_pc`=3.
- Redirect versus HALT in the same cycle: PC=1 with mem[1]=8'hFF, redirect to 8'h04.
  - `halted` stays 0; the next IR comes from address 4.
- Wrap and halted-ignore:
  - PC at 8'hFF with a non-HALT instruction → PC becomes 8'h00.
  - In HALTED, pulse `redirect_valid` → no change to PC or `halted`.
- Reset mid-stall: assert `reset` while `ir_valid`=1 and `ir_ready`=0.
  - Next edge: `ir_valid`=0, `pc_out`=`RESET_PC`, `halted`=0.
